// File: rtl/decim_pkg.sv
// rtl/decim_pkg.sv - shared constants and helpers for the multichannel decimator
package decim_pkg;

    // Ratio in force after reset unless the instance overrides it.
    localparam int DEF_RATIO_DEFAULT = 200;

    // Clocks per input sample. Returns 0 when the division is not exact so the
    // caller's range check (>= 2) rejects the configuration at elaboration.
    function automatic int calc_sample_div(input int sys, input int mix);
        if (mix <= 0) return 0;
        if ((sys % mix) != 0) return 0;
        return sys / mix;
    endfunction

    // LSB position of channel c in a packed multichannel word.
    function automatic int ch_lsb(input int c, input int dw);
        return c * dw;
    endfunction

endpackage

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - free-running prescaler producing a one-clock sample enable
// Ports:
//   clk_i   system clock
//   rstn_i  synchronous active-low reset
//   clr_i   restart the prescaler at 0 (phase realign)
//   tick_o  high for the last clock of every DIV-clock period
module clk_en_gen #(
    parameter int DIV = 20
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick_o = (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (clr_i || tick_o) presc_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) presc_q <= '0;
        else         presc_q <= presc_d;
    end

endmodule

// File: rtl/decim_mc.sv
// rtl/decim_mc.sv - runtime-programmable multichannel decimator with valid/ready output
// Ports:
//   clk, rstn         system clock, synchronous active-low reset
//   en                ratio counter enable (prescaler keeps running)
//   sync              realign pulse: restart prescaler and frame, reload ratio
//   ratio             requested decimation ratio (0 and 1 both mean 1)
//   din               NCH packed signed samples, channel c at [c*DW +: DW]
//   dout, dout_valid  held decimated sample set and its valid flag
//   dout_ready        consumer accept
//   overflow, ovf_clr sticky lost-sample flag and its clear
module decim_mc
    import decim_pkg::*;
#(
    parameter int DW           = 40,
    parameter int NCH          = 2,
    parameter int SYS_CLK_FREQ = 6_400_000,
    parameter int MIXING_FREQ  = 320_000,
    parameter int RATIO_W      = 9,
    parameter int DEF_RATIO    = decim_pkg::DEF_RATIO_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                sync,
    input  logic [RATIO_W-1:0]  ratio,
    input  logic [NCH*DW-1:0]   din,
    output logic [NCH*DW-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                overflow,
    input  logic                ovf_clr
);

    localparam int SAMPLE_DIV = calc_sample_div(SYS_CLK_FREQ, MIXING_FREQ);

    if (SAMPLE_DIV < 2) begin : g_bad_div
        $error("decim_mc: SYS_CLK_FREQ/MIXING_FREQ must be an exact integer >= 2");
    end

    logic tick;

    clk_en_gen #(
        .DIV (SAMPLE_DIV)
    ) u_clk_en_gen (
        .clk_i  (clk),
        .rstn_i (rstn),
        .clr_i  (sync),
        .tick_o (tick)
    );

    logic [RATIO_W-1:0] cnt_q,   cnt_d;
    logic [RATIO_W-1:0] r_act_q, r_act_d;
    logic [RATIO_W-1:0] r_eff;
    logic [NCH*DW-1:0]  dout_q,  dout_d;
    logic               valid_q, valid_d;
    logic               ovf_q,   ovf_d;
    logic               capture;

    // 0 and 1 both decimate by one.
    assign r_eff   = (r_act_q < RATIO_W'(2)) ? RATIO_W'(1) : r_act_q;
    // sync suppresses a coincident capture.
    assign capture = !sync && tick && en && (cnt_q == r_eff - RATIO_W'(1));

    always_comb begin
        cnt_d   = cnt_q;
        r_act_d = r_act_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (sync) begin
            cnt_d   = '0;
            r_act_d = ratio;
        end else if (tick && en) begin
            if (capture) begin
                cnt_d   = '0;
                r_act_d = ratio;
            end else begin
                cnt_d = cnt_q + RATIO_W'(1);
            end
        end

        for (int c = 0; c < NCH; c++) begin
            if (capture) dout_d[ch_lsb(c, DW) +: DW] = din[ch_lsb(c, DW) +: DW];
        end

        if (capture)                    valid_d = 1'b1;
        else if (valid_q && dout_ready) valid_d = 1'b0;

        // Set beats clear when both happen together.
        if (capture && valid_q && !dout_ready) ovf_d = 1'b1;
        else if (ovf_clr)                      ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q   <= '0;
            r_act_q <= RATIO_W'(DEF_RATIO);
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            r_act_q <= r_act_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_decim_mc.sv
// tb/tb_decim_mc.sv - randomized self-checking bench for decim_mc
module tb_decim_mc;

    localparam int DIV = 20;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, en, sync, dout_ready, ovf_clr;
    logic [8:0]  ratio;
    logic [79:0] din, dout;
    logic        dout_valid, overflow;
    logic [63:0] din2, dout2;
    logic        dout_valid2, overflow2;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 0;
    bit ramp   = 0;

    decim_mc u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .sync       (sync),
        .ratio      (ratio),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    decim_mc #(.DW(16), .NCH(4)) u_dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .sync       (sync),
        .ratio      (ratio),
        .din        (din2),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .dout_ready (dout_ready),
        .overflow   (overflow2),
        .ovf_clr    (ovf_clr)
    );

    // Reference model: edge count since reset, sample phase, frame position.
    int          rel, m_presc, m_cnt, m_r, rr;
    bit          tk, cap, m_valid, m_ovf;
    logic [79:0] m_dout;
    logic [63:0] m_dout2;
    int          cap_q[$];

    always @(posedge clk) begin
        if (!rstn) begin
            rel = 0; m_presc = 0; m_cnt = 0; m_r = 200;
            m_dout = '0; m_dout2 = '0; m_valid = 0; m_ovf = 0;
        end else begin
            rel++;
            tk  = (m_presc == DIV - 1);
            cap = 0;
            if (sync) begin
                m_presc = 0; m_cnt = 0; m_r = int'(ratio);
            end else begin
                m_presc = (m_presc + 1) % DIV;
                if (tk && en) begin
                    rr = (m_r < 2) ? 1 : m_r;
                    m_cnt++;
                    if (m_cnt == rr) begin
                        cap = 1; m_cnt = 0; m_r = int'(ratio);
                    end
                end
            end
            if (cap && m_valid && !dout_ready) m_ovf = 1;
            else if (ovf_clr)                  m_ovf = 0;
            if (cap) begin
                m_dout = din; m_dout2 = din2; m_valid = 1;
                cap_q.push_back(rel);
            end else if (m_valid && dout_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("dout",      128'(dout),        128'(m_dout));
            chk("valid",     128'(dout_valid),  128'(m_valid));
            chk("overflow",  128'(overflow),    128'(m_ovf));
            chk("dout4",     128'(dout2),       128'(m_dout2));
            chk("valid4",    128'(dout_valid2), 128'(m_valid));
            chk("overflow4", 128'(overflow2),   128'(m_ovf));
        end
    end

    task automatic set_ramp(input int e);
        logic [39:0] v;
        v    = 40'(e);
        din  = {-v, v};
        din2 = {16'(e + 3*4096), 16'(e + 2*4096), 16'(e + 4096), 16'(e)};
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ramp) set_ramp(rel + 1);
        end
    endtask

    task automatic wait_cap(input int k, input int budget);
        int t;
        t = 0;
        while (cap_q.size() < k && t < budget) begin
            step(1);
            t++;
        end
        if (cap_q.size() < k) begin
            total++; bad++;
            $display("FAIL wait_cap: got %0d captures expected %0d", cap_q.size(), k);
        end
    endtask

    int n, e0, s;

    initial begin
        rstn = 0; en = 0; sync = 0; dout_ready = 1; ovf_clr = 0;
        ratio = 9'd200; din = '0; din2 = '0;
        step(3);
        cmp_on = 1;
        chk("rst_dout",  128'(dout),       128'(0));
        chk("rst_valid", 128'(dout_valid), 128'(0));
        chk("rst_ovf",   128'(overflow),   128'(0));

        // Default ratio, ramp data.
        rstn = 1; en = 1; ramp = 1; set_ramp(1);
        wait_cap(1, 4100);
        chk("first_cap_edge", 128'(cap_q[0]), 128'(4000));
        chk("cap_ch0",        128'(dout[39:0]),  128'(40'd4000));
        chk("cap_ch1",        128'(dout[79:40]), 128'(40'hFF_FFFF_F060));
        chk("cap4_ch2",       128'(dout2[47:32]), 128'(16'd12192));
        step(1);
        chk("valid_pulse",    128'(dout_valid), 128'(0));
        wait_cap(3, 8100);
        chk("cap2_edge", 128'(cap_q[1]), 128'(8000));
        chk("cap3_edge", 128'(cap_q[2]), 128'(12000));

        // Mid-frame ratio change waits for the frame end.
        step(1000);
        ratio = 9'd4;
        wait_cap(6, 4000);
        chk("ratio_frame_end", 128'(cap_q[3]), 128'(16000));
        chk("ratio4_a",        128'(cap_q[4]), 128'(16080));
        chk("ratio4_b",        128'(cap_q[5]), 128'(16160));
        ratio = 9'd0;
        wait_cap(8, 200);
        chk("ratio0_a", 128'(cap_q[6]), 128'(16240));
        chk("ratio0_b", 128'(cap_q[7]), 128'(16260));
        ratio = 9'd1;
        wait_cap(10, 100);
        chk("ratio1_a", 128'(cap_q[8]), 128'(16280));
        chk("ratio1_b", 128'(cap_q[9]), 128'(16300));

        // Backpressure across captures.
        dout_ready = 0;
        wait_cap(11, 100);
        chk("bp_ovf",   128'(overflow),   128'(1));
        chk("bp_valid", 128'(dout_valid), 128'(1));
        chk("bp_dout",  128'(dout[39:0]), 128'(40'd16320));
        ovf_clr = 1;
        step(1);
        ovf_clr = 0;
        chk("ovf_clr",       128'(overflow),   128'(0));
        chk("ovf_clr_valid", 128'(dout_valid), 128'(1));
        dout_ready = 1;
        wait_cap(13, 100);
        dout_ready = 0;
        step(19);
        dout_ready = 1;
        step(1);
        chk("coinc_valid", 128'(dout_valid),   128'(1));
        chk("coinc_ovf",   128'(overflow),     128'(0));
        chk("coinc_ncap",  128'(cap_q.size()), 128'(14));

        // en low for exactly 10 ticks.
        ratio = 9'd200;
        n = cap_q.size();
        wait_cap(n + 1, 100);
        e0 = cap_q[n];
        step(1000);
        en = 0;
        step(200);
        en = 1;
        wait_cap(n + 2, 5000);
        chk("en_gap", 128'(cap_q[n + 1] - e0), 128'(4200));

        // sync at cnt = 150 with a pending sample.
        dout_ready = 0;
        step(3019);
        sync = 1;
        step(1);
        sync = 0;
        s = rel;
        chk("sync_valid", 128'(dout_valid),   128'(1));
        chk("sync_nocap", 128'(cap_q.size()), 128'(n + 2));
        wait_cap(n + 3, 4100);
        chk("sync_gap", 128'(cap_q[n + 2] - s), 128'(4000));
        dout_ready = 1; ovf_clr = 1;
        step(2);
        ovf_clr = 0;

        // Randomized traffic.
        ramp = 0;
        ratio = 9'd3;
        for (int i = 0; i < 20000; i++) begin
            din        = {$urandom, $urandom, $urandom};
            din2       = {$urandom, $urandom};
            en         = ($urandom % 8) != 0;
            dout_ready = ($urandom % 3) != 0;
            ovf_clr    = ($urandom % 50) == 0;
            sync       = ($urandom % 500) == 0;
            if (($urandom % 300) == 0) ratio = 9'($urandom_range(0, 6));
            step(1);
        end

        // Reset while valid and overflow are set.
        ratio = 9'd1; en = 1; sync = 0; ovf_clr = 0; dout_ready = 0;
        step(200);
        chk("pre_rst_valid", 128'(dout_valid), 128'(1));
        chk("pre_rst_ovf",   128'(overflow),   128'(1));
        rstn = 0; ratio = 9'd5;
        step(1);
        chk("mid_rst_dout",  128'(dout),       128'(0));
        chk("mid_rst_dout4", 128'(dout2),      128'(0));
        chk("mid_rst_valid", 128'(dout_valid), 128'(0));
        chk("mid_rst_ovf",   128'(overflow),   128'(0));
        rstn = 1; dout_ready = 1;
        cap_q.delete();
        wait_cap(2, 4200);
        chk("post_rst_cap1", 128'(cap_q[0]), 128'(4000));
        chk("post_rst_cap2", 128'(cap_q[1]), 128'(4100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decim_mc.md
# decim_mc

Multichannel, runtime-programmable decimator for the demodulator datapath. It generates the mixing-rate sample enable internally from the system clock, then keeps every R-th sample of NCH parallel channels (e.g. I/Q from the CIC integrators). It replaces the single-channel fixed-ratio decimator with:

- a runtime decimation ratio,
- a phase-realignment input,
- a valid/ready output handshake with overflow detection.

It sits between the CIC integrator section and the comb/demodulator stage.

## Interface

Parameters:
- DW, 40, bits per channel sample (signed)
- NCH, 2, number of channels captured in lockstep
- SYS_CLK_FREQ, 6_400_000, system clock frequency (Hz)
- MIXING_FREQ, 320_000, input sample rate (Hz); SAMPLE_DIV = SYS_CLK_FREQ/MIXING_FREQ, must be an integer ≥ 2
- RATIO_W, 9, width of the ratio port
- DEF_RATIO, 200, ratio in force after reset

Ports:
- clk, input, 1, system clock
- rstn, input, 1, reset; synchronous, active-low
- en, input, 1, decimation enable; when low the ratio counter freezes
- sync, input, 1, phase realign pulse
- ratio, input, RATIO_W, requested decimation ratio R
- din, input, NCH*DW, channel c occupies bits [c*DW +: DW], signed
- dout, output, NCH*DW, held decimated samples, same packing as din
- dout_valid, output, 1, dout holds an unconsumed sample set
- dout_ready, input, 1, consumer accepts dout when high together with dout_valid
- overflow, output, 1, sticky flag: a sample set was overwritten before it was accepted
- ovf_clr, input, 1, clears overflow

## Operation

- **Prescaler.** presc counts 0..SAMPLE_DIV-1 and wraps. tick = (presc == SAMPLE_DIV-1). The prescaler runs regardless of en.
- **Ratio counter.** cnt advances on tick && en.
  - At tick && en && cnt == r_act-1: cnt wraps to 0, all NCH channels of din are captured into dout, and r_act loads from ratio.
- **Ratio clamping.** A ratio value of 0 or 1 is treated as 1, which captures on every enabled tick.
- **Ratio changes.** A change on the ratio port takes effect only at the next wrap or sync, never mid-frame.
- **sync.** presc and cnt go to 0 and r_act loads from ratio. No capture occurs in the sync cycle, even if a tick coincides. dout, dout_valid and overflow are unaffected.
- **Handshake.**
  - dout_valid sets on capture.
  - dout_valid clears on dout_valid && dout_ready when no capture occurs in the same cycle.
  - dout is stable while dout_valid && !dout_ready, unless it is overwritten (see below).
- **Capture and accept in the same cycle.** The new data loads and dout_valid stays 1. This is not an overflow.
- **Capture while dout_valid && !dout_ready.** The new data overwrites dout, dout_valid stays 1, and overflow sets.
- **Overflow clear.** ovf_clr clears overflow. If a set condition occurs in the same cycle, set wins.
- **Reset** (rstn low at a clock edge), including mid-frame:
  - presc = 0, cnt = 0, r_act = DEF_RATIO
  - dout = 0, dout_valid = 0, overflow = 0
- **Arithmetic.** No arithmetic is performed on din; samples pass through bit-exact. cnt is RATIO_W bits wide.

## Timing

- All state is registered. Outputs change only on rising clk edges.
- **Capture latency.** dout and dout_valid reflect a capture one edge after the capture condition: the registered outputs change at the capture edge.
- **First capture after reset.** Counting the first edge with rstn high as edge 1, tick is true before edge k·SAMPLE_DIV. With constant en = 1, the first capture is at edge SAMPLE_DIV·DEF_RATIO. Defaults give edge 4000.
- **Steady-state period.** One capture per SAMPLE_DIV·R clocks.
- **Acceptance.** dout_ready is sampled combinationally with dout_valid at the edge. There is no ready-to-valid combinational path.
- **en low on a tick.** That tick is lost; it is not deferred.

## Structure

- **Package decim_pkg:**
  - function calc_sample_div(sys, mix), with an elaboration-time check for integer division and a result ≥ 2
  - localparam default DEF_RATIO
  - a channel-slice helper
- **Sub-module clk_en_gen:** parametrised prescaler producing tick, with its own synchronous active-low reset and a sync-clear input. It is reused by the mixer.
- **Top level:** ratio counter, capture register and handshake/overflow logic live in decim_mc.

## Test plan

- **Reset and default ratio.** Defaults, en = 1, ready = 1, din ramps per cycle → dout_valid pulses for one cycle at edges 4000, 8000, 12000. dout equals din sampled at those edges.
- **Runtime ratio.** Switch ratio from 200 to 4 mid-frame → the current frame still ends at 200 ticks. The following captures are 80 clocks apart. Ratio 0 and ratio 1 → a capture every 20 clocks.
- **Backpressure and overflow.** ready = 0 across two captures → dout_valid stays 1, dout is updated to the second sample set, and overflow = 1. ovf_clr then clears it. Capture coincident with accept → valid stays 1 and overflow stays 0.
- **en gating.** en low for 10 ticks → the next capture is delayed by exactly 10·20 clocks.
- **sync.** sync asserted at cnt = 150 → no capture that cycle, and the next capture comes 200·20 clocks later. Pending dout_valid is retained.
- **Reset mid-operation.** Assert rstn low while dout_valid = 1 and overflow = 1 → all outputs are 0 after the edge, and the next capture is at 4000 edges after release. NCH = 4 with DW = 16 → per-channel packing is verified.
